// File: rtl/cnt_pkg.sv
// Shared encodings and sizing helper for the counter bank.
package cnt_pkg;

    // Per-channel counting modes
    localparam logic [1:0] MODE_UP    = 2'b00;
    localparam logic [1:0] MODE_DN    = 2'b01;
    localparam logic [1:0] MODE_REV   = 2'b10;
    localparam logic [1:0] MODE_LDREV = 2'b11;

    // Tick source selection
    localparam logic [1:0] RATE_BTN  = 2'b00;
    localparam logic [1:0] RATE_FAST = 2'b01;
    localparam logic [1:0] RATE_SLOW = 2'b10;
    localparam logic [1:0] RATE_05HZ = 2'b11;

    // Bits needed to hold the values 0..v-1; never less than 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned     r;
        longint unsigned p;
        r = 0;
        p = 1;
        while (p < 64'(v)) begin
            p = p << 1;
            r = r + 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cnt_tick_gen.sv
// Count-strobe generator: button synchroniser with edge detect, or a prescaler
// at one of three rates. Emits a registered one-cycle tick.
module cnt_tick_gen
    import cnt_pkg::*;
#(
    parameter int unsigned DIV_FAST = 5_000_000,
    parameter int unsigned DIV_SLOW = 25_000_000,
    parameter int unsigned DIV_05HZ = 100_000_000
) (
    input  logic       clk_50MHz,
    input  logic       R,
    input  logic       en,
    input  logic       step_btn,
    input  logic [1:0] rate_sel,
    output logic       tick
);

    localparam int unsigned DIV_FS  = (DIV_FAST > DIV_SLOW) ? DIV_FAST : DIV_SLOW;
    localparam int unsigned DIV_MAX = (DIV_FS > DIV_05HZ) ? DIV_FS : DIV_05HZ;
    localparam int unsigned PW      = clog2(DIV_MAX);

    localparam logic [PW-1:0] FAST_LAST = PW'(DIV_FAST - 1);
    localparam logic [PW-1:0] SLOW_LAST = PW'(DIV_SLOW - 1);
    localparam logic [PW-1:0] HZ05_LAST = PW'(DIV_05HZ - 1);

    logic [1:0]    sync_q, sync_d;
    logic          prev_q, prev_d;
    logic [1:0]    rate_q, rate_d;
    logic [PW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;
    logic [PW-1:0] cnt_last;
    logic          btn_edge;

    // Next-state for synchroniser, edge detector, prescaler and tick strobe
    always_comb begin
        sync_d   = {sync_q[0], step_btn};
        prev_d   = sync_q[1];
        rate_d   = rate_sel;
        cnt_d    = cnt_q;
        tick_d   = 1'b0;
        btn_edge = sync_q[1] & ~prev_q;
        case (rate_sel)
            RATE_FAST: cnt_last = FAST_LAST;
            RATE_SLOW: cnt_last = SLOW_LAST;
            RATE_05HZ: cnt_last = HZ05_LAST;
            default:   cnt_last = '0;
        endcase
        if (rate_sel != rate_q) begin
            // Restart the period cleanly on any rate switch; no tick this cycle
            cnt_d = '0;
        end else if (rate_sel == RATE_BTN) begin
            cnt_d  = '0;
            tick_d = en & btn_edge;
        end else if (en) begin
            if (cnt_q == cnt_last) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + PW'(1);
            end
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk_50MHz or negedge R) begin
        if (!R) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rate_q <= '0;
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            rate_q <= rate_d;
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/cnt_bank_param.sv
// Bank of CH modulo-MOD counters sharing one count strobe, with per-channel
// up/down/rev/rev+load modes and a shared clamped load value.
module cnt_bank_param
    import cnt_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned CH       = 4,
    parameter int unsigned MOD      = 16,
    parameter int unsigned DIV_FAST = 5_000_000,
    parameter int unsigned DIV_SLOW = 25_000_000,
    parameter int unsigned DIV_05HZ = 100_000_000
) (
    input  logic                clk_50MHz,
    input  logic                R,
    input  logic                en,
    input  logic                load,
    input  logic                rev,
    input  logic                step_btn,
    input  logic [1:0]          rate_sel,
    input  logic [2*CH-1:0]     mode,
    input  logic [WIDTH-1:0]    D,
    output logic [CH*WIDTH-1:0] Q,
    output logic [CH-1:0]       tc,
    output logic                tick
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MOD - 1);

    logic [WIDTH-1:0] d_clamped;

    // Out-of-range load data saturates to the top count
    assign d_clamped = (D > LAST) ? LAST : D;

    cnt_tick_gen #(
        .DIV_FAST (DIV_FAST),
        .DIV_SLOW (DIV_SLOW),
        .DIV_05HZ (DIV_05HZ)
    ) u_tick_gen (
        .clk_50MHz (clk_50MHz),
        .R         (R),
        .en        (en),
        .step_btn  (step_btn),
        .rate_sel  (rate_sel),
        .tick      (tick)
    );

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [1:0]       ch_mode;
        logic             count_dn;
        logic [WIDTH-1:0] q_q, q_d;
        logic             tc_q, tc_d;

        assign ch_mode = mode[2*i +: 2];

        // Channel next-state: load wins over a same-cycle tick and never flags tc
        always_comb begin
            case (ch_mode)
                MODE_UP: count_dn = 1'b0;
                MODE_DN: count_dn = 1'b1;
                default: count_dn = rev;
            endcase
            q_d  = q_q;
            tc_d = 1'b0;
            if (en && load && (ch_mode == MODE_LDREV)) begin
                q_d = d_clamped;
            end else if (en && tick) begin
                if (count_dn) begin
                    if (q_q == '0) begin
                        q_d  = LAST;
                        tc_d = 1'b1;
                    end else begin
                        q_d = q_q - WIDTH'(1);
                    end
                end else begin
                    if (q_q == LAST) begin
                        q_d  = '0;
                        tc_d = 1'b1;
                    end else begin
                        q_d = q_q + WIDTH'(1);
                    end
                end
            end
        end

        // Channel count and terminal-count registers
        always_ff @(posedge clk_50MHz or negedge R) begin
            if (!R) begin
                q_q  <= '0;
                tc_q <= 1'b0;
            end else begin
                q_q  <= q_d;
                tc_q <= tc_d;
            end
        end

        assign Q[WIDTH*i +: WIDTH] = q_q;
        assign tc[i]               = tc_q;
    end

endmodule

// File: doc/cnt_bank_param.md
Name: cnt_bank_param

Overview:
Parametrised bank of CH modulo-MOD counters, WIDTH bits each, sharing one count-enable strobe. Per-channel runtime mode: up, down, rev-controlled, or rev-controlled with parallel load. Replaces derived-clock counting with a single clk_50MHz domain: the button, the two prescaler rates and the 0.5 Hz rate become one-cycle tick strobes. Sits between the board inputs and the 7-segment drivers; each channel's Q slice feeds one driver.

Parameters:
WIDTH, 4, bits per counter channel.
CH, 4, number of counter channels.
MOD, 16, count modulus; legal range 2..2**WIDTH; counters run 0..MOD-1.
DIV_FAST, 5_000_000, clk_50MHz cycles per tick for rate_sel=01.
DIV_SLOW, 25_000_000, clk_50MHz cycles per tick for rate_sel=10.
DIV_05HZ, 100_000_000, clk_50MHz cycles per tick for rate_sel=11.

Ports:
clk_50MHz  in  1  system clock; all state on its rising edge.
R  in  1  asynchronous active-low reset.
en  in  1  global enable; 0 freezes prescaler, counters and load.
load  in  1  synchronous parallel load request; affects mode-11 channels only.
rev  in  1  direction for modes 10/11: 0 = up, 1 = down.
step_btn  in  1  debounced manual step level, asynchronous to clk_50MHz.
rate_sel  in  2  tick source: 00 btn, 01 DIV_FAST, 10 DIV_SLOW, 11 DIV_05HZ.
mode  in  2*CH  per-channel mode, channel i at [2i+1:2i]: 00 up, 01 down, 10 rev, 11 rev+load.
D  in  WIDTH  load data shared by all mode-11 channels.
Q  out  CH*WIDTH  counter values; channel i at [WIDTH*i+WIDTH-1:WIDTH*i].
tc  out  CH  per-channel terminal-count strobe, one cycle.
tick  out  1  registered count strobe, one cycle.

Behaviour:
- Reset (R=0, async): Q=0, tc=0, tick=0, prescaler=0, sync/edge flops=0. Release is synchronous to the next clock edge.
- Button path: 2-FF synchroniser, then a rising-edge detector. step_btn rising before edge k gives tick=1 in the cycle after edge k+2, i.e. 3 edges of latency. A held button gives exactly one tick.
- Prescaler: one counter 0..DIV-1 for the selected DIV. At DIV-1 it wraps to 0, and tick=1 for the next cycle. Period is exactly DIV cycles.
- Any change of rate_sel clears the prescaler to 0 and suppresses tick for that cycle.
- en=0: prescaler holds, button edges are discarded, tick=0, Q holds, tc=0.
- Counting happens on an edge where tick=1 and en=1, and Q shows the result the following cycle.
  - Up: MOD-1 -> 0 wraps and sets tc[i]=1 for that cycle.
  - Down: 0 -> MOD-1 wraps and sets tc[i]=1.
  - Mode 10/11 direction is taken from rev sampled on the same edge.
- Load: on any edge with en=1 and load=1, every mode-11 channel takes Q=D, regardless of tick.
  - D >= MOD is clamped to MOD-1.
  - Load beats a same-cycle tick, with no tc.
  - Channels in modes 00/01/10 ignore load.
- Mode change takes effect on the next tick; Q is not modified by the change itself.
- tc registered alongside Q; otherwise 0.
- MOD not a power of two: wrap compares against MOD-1 explicitly; no Q value >= MOD is ever produced.
- Reset mid-count or mid-prescale returns everything to reset values immediately. The first tick after release needs a full DIV period or a new button edge.

Decomposition:
- Package cnt_pkg holds:
  - mode encodings MODE_UP, MODE_DN, MODE_REV, MODE_LDREV (2 bits);
  - rate encodings RATE_BTN, RATE_FAST, RATE_SLOW, RATE_05HZ;
  - function clog2 for sizing the prescaler as clog2(max DIV).
- Sub-module cnt_tick_gen contains the synchroniser, edge detect, prescaler, rate mux and rate_sel change detect, and outputs tick.
- Channels are a generate loop in cnt_bank_param. No per-channel sub-module.

Test Plan:
- Reset/up wrap: WIDTH=4, CH=2, MOD=10, DIV_FAST=4, mode={01,00}, rate_sel=01, en=1 -> tick every 4 cycles. Ch0 steps 0..9 -> 0 with tc[0] on the 9->0 tick. Ch1 goes 0 -> 9 on the first tick with tc[1]=1. R pulled low mid-run -> Q=0, tc=0, tick=0 immediately.
- Button: rate_sel=00, step_btn held high 20 cycles -> exactly one tick, 3 edges after the rise. Ch0 0 -> 1. Second press -> 2.
- Rev/load priority: mode=11, rev=1, Q=3, D=7, load=1 on the same cycle as tick -> Q=7, no tc. Next tick with load=0 -> 6. D=12 with MOD=10 -> Q=9.
- Load ignored: mode=10, load=1, D=5 -> Q unchanged until tick. en=0 with load=1 -> no change, tick=0.
- Rate switch: DIV_FAST=4, DIV_SLOW=6, switch 01 -> 10 mid-period -> no tick in the switch cycle. Next tick exactly 6 cycles later.
- Down wrap with rev: mode=10, rev=1 from Q=0 -> Q=MOD-1=9, tc=1 for one cycle. rev=0 -> 9 -> 0 with tc=1.
